vga_fb_arbiter: RTL and testbench

Arbitrates a single-port framebuffer RAM between two users. The scanout path prefetches pixels into an internal FIFO, which the pixel stage of the VGA timing driver drains during active video. A drawing engine writes pixels through a valid/ready port. The block sits between the RAM, the pattern/pixel source of the XGA top level, and the vga_driver colour inputs, in the clk_75 domain.

---
 rtl/vga_fb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter between VGA scanout prefetch and a pixel writer
// Scanout reads reserve a FIFO slot at grant, so the prefetch FIFO can never overflow.

module vga_fb_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     not_empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign not_empty = (count_q != '0);
    assign head      = not_empty ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
endmodule

module vga_fb_arbiter #(
    parameter int WIDTH      = 1024,
    parameter int HEIGHT     = 768,
    parameter int PIXEL_W    = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4,
    parameter int ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_sync,
    input  logic               pix_rd,
    output logic [PIXEL_W-1:0] pix_data,
    output logic               pix_valid,
    output logic               underflow,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [PIXEL_W-1:0] mem_wdata,
    input  logic [PIXEL_W-1:0] mem_rdata
);
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LVL_W = CNT_W + 1;

    logic [ADDR_W-1:0]  fp_q, fp_d;
    logic [1:0]         inf_q, inf_d;
    logic               rd_ret_q, rd_ret_d;
    logic               rd_stale_q, rd_stale_d;
    logic               underflow_q, underflow_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [PIXEL_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [CNT_W-1:0]   fifo_count;
    logic [LVL_W-1:0]   level;
    logic               urgent, grant_rd, grant_wr, push_en;

    vga_fb_fifo #(
        .DATA_W (PIXEL_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_sync),
        .push      (push_en),
        .push_data (mem_rdata),
        .pop       (pix_rd),
        .head      (pix_data),
        .not_empty (pix_valid),
        .count     (fifo_count)
    );

    always_comb begin
        level    = LVL_W'(fifo_count) + LVL_W'(inf_q);
        urgent   = (level <= LVL_W'(LOW_WM));
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (!rst && !frame_sync) begin
            if (urgent)                            grant_rd = 1'b1;
            else if (wr_valid)                     grant_wr = 1'b1;
            else if (level < LVL_W'(FIFO_DEPTH))   grant_rd = 1'b1;
        end
        wr_ready = !rst && !frame_sync && !urgent;

        // Stale returns still retire their slot in inf but never reach the FIFO.
        push_en     = rd_ret_q && !rd_stale_q;
        rd_ret_d    = mem_en_q && !mem_we_q;
        rd_stale_d  = frame_sync;
        inf_d       = inf_q + 2'(grant_rd) - 2'(rd_ret_q);
        underflow_d = underflow_q || (pix_rd && !pix_valid);

        fp_d = fp_q;
        if (frame_sync)                           fp_d = '0;
        else if (grant_rd)                        fp_d = (fp_q == ADDR_W'(TOTAL - 1)) ? '0 : fp_q + 1'b1;

        mem_en_d    = grant_rd || grant_wr;
        mem_we_d    = grant_wr;
        mem_addr_d  = grant_rd ? fp_q : (grant_wr ? wr_addr : mem_addr_q);
        mem_wdata_d = grant_wr ? wr_data : mem_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fp_q        <= '0;
            inf_q       <= '0;
            rd_ret_q    <= 1'b0;
            rd_stale_q  <= 1'b0;
            underflow_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            fp_q        <= fp_d;
            inf_q       <= inf_d;
            rd_ret_q    <= rd_ret_d;
            rd_stale_q  <= rd_stale_d;
            underflow_q <= underflow_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign underflow = underflow_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard bench for vga_fb_arbiter on a reduced 32x16 frame

module tb_vga_fb_arbiter;
    localparam int WIDTH      = 32;
    localparam int HEIGHT     = 16;
    localparam int TOTAL      = WIDTH * HEIGHT;
    localparam int PIXEL_W    = 24;
    localparam int FIFO_DEPTH = 16;
    localparam int LOW_WM     = 4;
    localparam int ADDR_W     = 9;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               frame_sync = 1'b0;
    logic               pix_rd = 1'b0;
    logic               wr_valid = 1'b0;
    logic [ADDR_W-1:0]  wr_addr = '0;
    logic [PIXEL_W-1:0] wr_data = '0;
    logic [PIXEL_W-1:0] pix_data, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0]  mem_addr;
    logic               pix_valid, underflow, wr_ready, mem_en, mem_we;

    int n_checks = 0;
    int n_errors = 0;

    logic [PIXEL_W-1:0]        exp_pix [$];
    logic [ADDR_W+PIXEL_W-1:0] exp_wr  [$];
    int  exp_rd_addr = 0;
    int  next_exp_a  = 0;
    bit  wr_done     = 1'b0;
    bit  prev_rst = 1'b1, prev_fs = 1'b0, prev_ready = 1'b0, prev_acc = 1'b0;
    int  urgent_cycles;
    bit  resumed;

    logic [PIXEL_W-1:0] ram_w  [TOTAL];
    bit                 ram_wv [TOTAL];

    vga_fb_arbiter #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .PIXEL_W    (PIXEL_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LOW_WM     (LOW_WM),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_sync (frame_sync),
        .pix_rd     (pix_rd),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .underflow  (underflow),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM holds data = address until a location is written.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram_w[mem_addr]  <= mem_wdata;
            ram_wv[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we)
            mem_rdata <= ram_wv[mem_addr] ? ram_w[mem_addr] : PIXEL_W'(mem_addr);
        else
            mem_rdata <= 24'hBADBAD;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PIXEL_W-1:0] img(input int a);
        return (a == 256 && wr_done) ? 24'hABCDEF : PIXEL_W'(a);
    endfunction

    task automatic expect_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            exp_pix.push_back(img(next_exp_a));
            next_exp_a = (next_exp_a + 1) % TOTAL;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_en"},    64'(mem_en),    64'd0);
        check({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
        check({tag, "_pix_data"},  64'(pix_data),  64'd0);
        check({tag, "_underflow"}, 64'(underflow), 64'd0);
        check({tag, "_wr_ready"},  64'(wr_ready),  64'd0);
    endtask

    // Scoreboard feed: every accepted write is an expected RAM write transaction.
    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready)
            exp_wr.push_back({wr_addr, wr_data});
    end

    // Monitor: compares popped pixels and RAM transactions against the queues.
    always @(negedge clk) begin
        if (rst) begin
            exp_rd_addr = 0;
            prev_acc    = 1'b0;
        end else begin
            if (pix_rd && pix_valid) begin
                if (exp_pix.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pix_unexpected: got 0x%0h, expected no pop", pix_data);
                end else begin
                    check("pix_data", 64'(pix_data), 64'(exp_pix.pop_front()));
                end
            end
            if (mem_en && !mem_we) begin
                check("rd_addr", 64'(mem_addr), 64'(exp_rd_addr));
                exp_rd_addr = (exp_rd_addr + 1) % TOTAL;
            end
            if (mem_en && mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
                end else begin
                    check("wr_txn", 64'({mem_addr, mem_wdata}), 64'(exp_wr.pop_front()));
                end
            end
            if (prev_acc)
                check("wr_after_accept", 64'(mem_en && mem_we), 64'd1);
            if (!prev_rst && !prev_fs && !prev_ready)
                check("urgent_read", 64'(mem_en && !mem_we), 64'd1);
            if (dut.push_en)
                check("fifo_overflow", 64'(dut.fifo_count == FIFO_DEPTH), 64'd0);
            if (frame_sync)
                exp_rd_addr = 0;
            prev_acc = wr_valid && wr_ready;
        end
        prev_rst   = rst;
        prev_fs    = frame_sync;
        prev_ready = wr_ready;
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        expect_pixels(256);

        // Reset fill: reads 0..15 on consecutive cycles, pix_valid at cycle 3.
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("fill_mem_en", 64'(mem_en), 64'(c >= 1 && c <= 16));
            if (c >= 1 && c <= 16) begin
                check("fill_addr", 64'(mem_addr), 64'(c - 1));
                check("fill_we", 64'(mem_we), 64'd0);
            end
            check("fill_pix_valid", 64'(pix_valid), 64'(c >= 3));
            if (c == 3) check("fill_pix_data", 64'(pix_data), 64'd0);
            @(posedge clk); #1;
        end

        // Steady drain at one pixel per clock.
        pix_rd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("drain_valid", 64'(pix_valid), 64'd1);
            @(posedge clk); #1;
        end
        pix_rd = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Write sharing with a full FIFO and slow drain.
        wr_valid = 1'b1;
        wr_addr  = 9'h100;
        wr_data  = 24'hABCDEF;
        for (int i = 0; i < 12; i++) begin
            pix_rd = (i % 4 == 0);
            @(negedge clk);
            check("share_wr_ready", 64'(wr_ready), 64'd1);
            @(posedge clk); #1;
        end

        // Urgency: fast drain starves the writer until the level recovers.
        pix_rd = 1'b1;
        urgent_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!wr_ready) urgent_cycles++;
            @(posedge clk); #1;
        end
        check("urgency_seen", 64'(urgent_cycles > 0), 64'd1);
        pix_rd  = 1'b0;
        resumed = 1'b0;
        for (int i = 0; i < 10 && !resumed; i++) begin
            @(negedge clk);
            if (wr_ready) resumed = 1'b1;
            @(posedge clk); #1;
        end
        check("urgency_release", 64'(resumed), 64'd1);
        wr_valid = 1'b0;
        wr_done  = 1'b1;
        expect_pixels(400);

        // Long drain through address 0x100 and across the frame wrap.
        pix_rd = 1'b1;
        repeat (450) @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_no_underflow", 64'(underflow), 64'd0);
        @(posedge clk); #1;

        // frame_sync with two reads in flight.
        frame_sync = 1'b1;
        pix_rd     = 1'b0;
        exp_pix.delete();
        next_exp_a = 0;
        expect_pixels(30);
        @(negedge clk);
        check("fs_inflight_read", 64'(mem_en && !mem_we), 64'd1);
        @(posedge clk); #1;
        frame_sync = 1'b0;
        pix_rd     = 1'b1;
        @(negedge clk);
        check("fs_flushed", 64'(pix_valid), 64'd0);
        @(posedge clk); #1;
        pix_rd = 1'b0;
        @(negedge clk);
        check("underflow_set", 64'(underflow), 64'd1);
        check("fs_valid_s2", 64'(pix_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fs_valid_s3", 64'(pix_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fs_valid_s4", 64'(pix_valid), 64'd1);
        check("fs_first_pixel", 64'(pix_data), 64'd0);
        @(posedge clk); #1;
        pix_rd = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        pix_rd = 1'b0;
        @(negedge clk);
        check("underflow_sticky", 64'(underflow), 64'd1);
        @(posedge clk); #1;

        // Reset asserted mid-operation with reads in flight.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pix.delete();
        next_exp_a = 0;
        expect_pixels(10);
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk); #1;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            check("midrst_pix_valid", 64'(pix_valid), 64'(c >= 3));
            if (c == 3) check("midrst_pix_data", 64'(pix_data), 64'd0);
            @(posedge clk); #1;
        end
        pix_rd = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        pix_rd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("writes_drained", 64'(exp_wr.size()), 64'd0);
        check("underflow_after_rst", 64'(underflow), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
